my_ram_param: RTL and testbench
===============================

Name: my_ram_param

Overview:
- Parametrised successor to the fixed 16-bit x 512 RAM: single-port word RAM, generic in data width and address width.
- Adds an asynchronous active-low reset, a hardware clear engine that zeroes every word, a busy flag, and a selectable registered read port.
- Used as the generic memory primitive for data memory and scratch buffers in the CPU datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 9, address width; depth is DEPTH = 2**ADDR_W words.
- REG_READ, 0, read mode: 0 = combinational read, 1 = registered read with 1-cycle latency.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data.
- addr  input  ADDR_W  read/write address.
- load  input  1  write enable, sampled at the rising edge of clk.
- clear  input  1  request to zero the whole array, sampled at the rising edge of clk.
- out  output  WIDTH  read data.
- busy  output  1  high while the clear engine runs; load and clear are ignored while busy is high.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - FSM = CLEAR, sweep counter = 0, busy = 1.
  - Output register = 0 (REG_READ=1); out = 0 in both modes.
- FSM states: CLEAR and IDLE.
- CLEAR state:
  - Each rising edge writes 0 to mem[cnt], then cnt increments.
  - When cnt = DEPTH-1 has been written, the FSM moves to IDLE and busy falls on that same edge.
  - The full sweep takes exactly DEPTH cycles after rst_n deasserts.
- IDLE state:
  - clear=1 at a rising edge enters CLEAR with cnt=0 and raises busy.
  - If load=1 on that same edge, the write is discarded: clear has priority.
- Write:
  - In IDLE with load=1 and clear=0, mem[addr] <= in on the rising edge.
  - Write data is never truncated; in is exactly WIDTH bits.
- Read, REG_READ=0:
  - out = mem[addr] combinationally whenever busy=0.
  - A write becomes visible immediately after the edge that performs it.
- Read, REG_READ=1:
  - out <= mem[addr] on each rising edge whenever busy=0.
  - If load=1 and the address matches on that edge, out takes the new data (write-first).
- While busy=1: out = 0 in both modes, and load has no effect.
- Reset asserted mid-sweep: the sweep restarts from cnt=0 after deassert. No partially cleared state is exposed, because busy stays high.
- Reset asserted mid-operation in IDLE: all contents are zeroed by the subsequent sweep.
- Address wrap: none is needed, since addr spans exactly DEPTH words. The counter compares against DEPTH-1 and does not rely on overflow.
- No X propagation: every word is defined (0) once busy first falls.

Test Plan:
- Reset and sweep (defaults):
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: busy=1 and out=0 for exactly 512 rising edges; busy=0 afterwards; reading addr 0, 9'h1FF and 9'h0A5 returns 0.
- Write/read (REG_READ=0):
  - Stimulus: write 2@0, 3@1, 4@2, 5@9'b000010011, 9@9'b110100111, 1@9'h1FF with load=1; then load=0 and read each address back.
  - Required: out equals the written value combinationally after addr changes, before any further clock edge.
- Registered read (REG_READ=1, WIDTH=8, ADDR_W=4):
  - Stimulus: write 8'hA5@3; read addr 3.
  - Required: out = 8'hA5 one edge after addr is applied, and is unchanged before that edge.
  - Stimulus: same-edge write 8'h3C@3 while addr=3.
  - Required: out = 8'h3C after that edge.
- Clear command:
  - Stimulus: write 7@9'h055; pulse clear=1 with load=1, in=16'hFFFF, addr=9'h055 on the same edge.
  - Required: busy high for 512 cycles; load pulses during the sweep have no effect; afterwards mem[9'h055] reads 0.
- Reset mid-sweep:
  - Stimulus: during a clear sweep, drive rst_n=0 asynchronously between clock edges at cycle 100.
  - Required: out=0 and busy=1 immediately; after release the sweep takes a full 512 cycles again; all words read 0.
- Load ignored while busy:
  - Stimulus: during the reset sweep, write 16'd9@9'h1A7.
  - Required: after busy falls, addr 9'h1A7 reads 0.

Source files
------------

// File: rtl/my_ram_param.sv
// Generic single-port word RAM with a hardware clear engine that zeroes the
// whole array after reset or on request; busy guards the array while sweeping.
module my_ram_param #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 9,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              busy_reg;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (cnt_reg == LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (clear) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

  // The sweep owns the write port; a user write needs IDLE and no clear request.
  assign wr_en   = (state_reg == CLEAR) || (load && !clear);
  assign wr_addr = (state_reg == CLEAR) ? cnt_reg : addr;
  assign wr_data = (state_reg == CLEAR) ? '0 : in;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign busy = busy_reg;

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] out_reg;

      // Write-first: a same-edge write to the read address forwards the new data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg <= '0;
        end else if (busy_reg) begin
          out_reg <= '0;
        end else if (load && !clear) begin
          out_reg <= in;
        end else begin
          out_reg <= mem[addr];
        end
      end

      assign out = busy_reg ? '0 : out_reg;
    end else begin : g_comb_read
      assign out = busy_reg ? '0 : mem[addr];
    end
  endgenerate

endmodule

// File: tb/tb_my_ram_param.sv
// Scoreboarded bench: a default combinational-read RAM and a small
// registered-read RAM share clock and reset.
module tb_my_ram_param;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] in_a;
  logic [8:0]  addr_a;
  logic        load_a, clear_a;
  logic [15:0] out_a;
  logic        busy_a;

  logic [7:0]  in_b;
  logic [3:0]  addr_b;
  logic        load_b, clear_b;
  logic [7:0]  out_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  my_ram_param dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .addr(addr_a),
    .load(load_a), .clear(clear_a), .out(out_a), .busy(busy_a)
  );

  my_ram_param #(.WIDTH(8), .ADDR_W(4), .REG_READ(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .addr(addr_b),
    .load(load_b), .clear(clear_b), .out(out_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("chk %s got %0h ok", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Combinational read on dut_a: compare before any further clock edge.
  task automatic read_a(input string tag, input logic [8:0] a, input logic [15:0] e);
    addr_a = a;
    exp_q.push_back({16'h0, e});
    #1;
    check_val(tag, {16'h0, out_a}, exp_q.pop_front());
  endtask

  // Counts edges until dut_a's busy falls; injects one load at edge burst_at.
  task automatic wait_sweep(input int burst_at, input logic [8:0] ba, input logic [15:0] bd,
                            output int n, output int nz);
    n  = 0;
    nz = 0;
    while (busy_a && n < 1000) begin
      if (n == burst_at) begin
        addr_a = ba;
        in_a   = bd;
        load_a = 1'b1;
      end
      tick();
      load_a = 1'b0;
      n++;
      if (busy_a && out_a !== 16'h0) nz++;
    end
  endtask

  logic [8:0]  wr_addr_t [6] = '{9'h000, 9'h001, 9'h002, 9'b000010011, 9'b110100111, 9'h1FF};
  logic [15:0] wr_data_t [6] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd9, 16'd1};

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, nz, bad;
    in_a = '0; addr_a = '0; load_a = 0; clear_a = 0;
    in_b = '0; addr_b = '0; load_b = 0; clear_b = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_busy", {31'h0, busy_a}, 32'd1);
    check_val("rst_out", {16'h0, out_a}, 32'd0);
    check_val("rst_out_b", {24'h0, out_b}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset sweep with a load attempted after the sweep has passed 9'h1A7.
    wait_sweep(500, 9'h1A7, 16'd9, n, nz);
    check_val("sweep_len", n, 32'd512);
    check_val("sweep_out0", nz, 32'd0);
    check_val("busy_b_done", {31'h0, busy_b}, 32'd0);
    read_a("rd0_post_rst", 9'h000, 16'h0);
    read_a("rd1ff_post_rst", 9'h1FF, 16'h0);
    read_a("rd0a5_post_rst", 9'h0A5, 16'h0);
    read_a("load_ignored_1a7", 9'h1A7, 16'h0);

    // Write and read back through the combinational port.
    for (int i = 0; i < 6; i++) begin
      addr_a = wr_addr_t[i];
      in_a   = wr_data_t[i];
      load_a = 1'b1;
      tick();
      load_a = 1'b0;
      exp_q.push_back({16'h0, wr_data_t[i]});
      check_val($sformatf("wr_vis_%0d", i), {16'h0, out_a}, exp_q.pop_front());
    end
    for (int i = 0; i < 6; i++)
      read_a($sformatf("rdback_%0d", i), wr_addr_t[i], wr_data_t[i]);

    // Registered read port.
    addr_b = 4'd3; in_b = 8'hA5; load_b = 1'b1;
    tick();
    load_b = 1'b0; addr_b = 4'd5;
    tick();
    check_val("regrd_other", {24'h0, out_b}, 32'h0);
    addr_b = 4'd3;
    #1;
    check_val("regrd_hold", {24'h0, out_b}, 32'h0);
    exp_q.push_back(32'hA5);
    tick();
    check_val("regrd_a5", {24'h0, out_b}, exp_q.pop_front());
    in_b = 8'h3C; load_b = 1'b1;
    exp_q.push_back(32'h3C);
    tick();
    load_b = 1'b0;
    check_val("regrd_wfirst", {24'h0, out_b}, exp_q.pop_front());
    exp_q.push_back(32'h3C);
    tick();
    check_val("regrd_after", {24'h0, out_b}, exp_q.pop_front());

    // Clear command wins over a same-edge load.
    addr_a = 9'h055; in_a = 16'd7; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    read_a("pre_clear_055", 9'h055, 16'd7);
    clear_a = 1'b1; load_a = 1'b1; in_a = 16'hFFFF;
    tick();
    clear_a = 1'b0; load_a = 1'b0;
    check_val("clr_busy", {31'h0, busy_a}, 32'd1);
    check_val("clr_out0", {16'h0, out_a}, 32'd0);
    wait_sweep(300, 9'h055, 16'hFFFF, n, nz);
    check_val("clr_len", n, 32'd512);
    check_val("clr_out_busy0", nz, 32'd0);
    read_a("post_clear_055", 9'h055, 16'h0);
    read_a("post_clear_1ff", 9'h1FF, 16'h0);

    // Fill some words, then reset part-way through a clear sweep.
    for (int i = 0; i < 16; i++) begin
      addr_a = 9'h100 + 9'(i);
      in_a   = 16'hA000 + 16'(i);
      load_a = 1'b1;
      tick();
    end
    load_a = 1'b0;
    read_a("fill_10f", 9'h10F, 16'hA00F);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    repeat (100) tick();
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'h0, busy_a}, 32'd1);
    check_val("midrst_out", {16'h0, out_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_sweep(2000, 9'h0, 16'h0, n, nz);
    check_val("midrst_len", n, 32'd512);
    check_val("midrst_out_busy0", nz, 32'd0);
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      addr_a = 9'(a);
      #1;
      if (out_a !== 16'h0) bad++;
    end
    check_val("all_zero", bad, 32'd0);

    // dut_b held data at 3 before the reset; its sweep must have zeroed it.
    addr_b = 4'd3;
    exp_q.push_back(32'h0);
    tick();
    check_val("b_zero_after_rst", {24'h0, out_b}, exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
